// File: rtl/ir_carrier_strip_pkg.sv
// ir_pkg: shared IR state encoding and default timing constants
package ir_pkg;
  typedef logic [0:0] ir_state_t;
  localparam ir_state_t IR_SPACE = 1'b1;
  localparam ir_state_t IR_MARK = 1'b0;
  localparam int HOLD_CYC_DEF = 2000;
  localparam int GLITCH_CYC_DEF = 8;
  localparam int LEN_W_DEF = 16;
endpackage

// File: rtl/ir_carrier_strip_if.sv
// ir_carrier_strip_if: raw IR line in, envelope and segment report out
interface ir_carrier_strip_if #(parameter int LEN_W = 16);
  logic ir_sd_i;
  logic ir_car_en_i;
  logic ir_env_o;
  logic [LEN_W-1:0] seg_len_o;
  logic seg_lvl_o;
  logic seg_vld_o;
  modport master (
    output ir_sd_i, ir_car_en_i,
    input ir_env_o, seg_len_o, seg_lvl_o, seg_vld_o
  );
  modport slave (
    input ir_sd_i, ir_car_en_i,
    output ir_env_o, seg_len_o, seg_lvl_o, seg_vld_o
  );
endinterface

// File: rtl/ir_carrier_strip_glitch_filt.sv
// ir_glitch_filt: passes a level only after it has been stable for GLITCH_CYC samples
module ir_glitch_filt #(
  parameter int GLITCH_CYC = 8
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_lvl
);
  localparam int W = $clog2(GLITCH_CYC + 1);
  logic r_lvl;
  logic [W-1:0] r_cnt;
  // count consecutive samples that disagree with the output; adopt the new level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= 1'b1;
      r_cnt <= '0;
    end else if (i_lvl == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == W'(GLITCH_CYC - 1)) begin
      r_lvl <= i_lvl;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_lvl = r_lvl;
endmodule

// File: rtl/ir_carrier_strip.sv
// ir_carrier_strip: strips the IR carrier into a mark/space envelope and reports segment lengths; IR_GLITCH_FILT_EN adds a glitch filter
module ir_carrier_strip
  import ir_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int LEN_W = LEN_W_DEF
`ifdef IR_GLITCH_FILT_EN
  , parameter int GLITCH_CYC = GLITCH_CYC_DEF
`endif
)(
  input logic clk,
  input logic rst_n,
  ir_carrier_strip_if.slave bus
);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  logic [1:0] r_sync;
  logic w_lvl;
  logic r_dly;
  logic w_edge;
  logic r_mode;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  ir_state_t r_state;
  ir_state_t w_state_nxt;
  logic w_go_mark;
  logic w_go_space;
  logic w_tr;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] r_len;
  logic r_lvl;
  logic r_vld;
  // two-flop synchroniser for the asynchronous receiver line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], bus.ir_sd_i};
  end
`ifdef IR_GLITCH_FILT_EN
  ir_glitch_filt #(.GLITCH_CYC(GLITCH_CYC)) u_filt (
    .clk(clk),
    .rst_n(rst_n),
    .i_lvl(r_sync[1]),
    .o_lvl(w_lvl)
  );
`else
  assign w_lvl = r_sync[1];
`endif
  assign w_edge = w_lvl ^ r_dly;
  assign w_hold_nxt = w_edge ? '0 : (r_hold == HOLD_W'(HOLD_CYC) ? r_hold : r_hold + 1'b1);
  assign w_go_mark = r_mode ? !w_lvl : (w_edge | !w_lvl);
  assign w_go_space = r_mode ? w_lvl : (w_hold_nxt == HOLD_W'(HOLD_CYC) && w_lvl);
  assign w_state_nxt = r_state == IR_SPACE ? (w_go_mark ? IR_MARK : IR_SPACE) : (w_go_space ? IR_SPACE : IR_MARK);
  assign w_tr = w_state_nxt != r_state;
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
  // edge delay, hold counter, and mode latch (mode only follows the detector while in space)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= 1'b1;
      r_hold <= '0;
      r_mode <= 1'b1;
    end else begin
      r_dly <= w_lvl;
      r_hold <= w_hold_nxt;
      r_mode <= r_state == IR_SPACE ? bus.ir_car_en_i : r_mode;
    end
  end
  // envelope state and segment measurement, reported on every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IR_SPACE;
      r_cnt <= '0;
      r_len <= '0;
      r_lvl <= 1'b1;
      r_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_tr ? '0 : w_cnt_inc;
      r_len <= w_tr ? w_cnt_inc : r_len;
      r_lvl <= w_tr ? r_state[0] : r_lvl;
      r_vld <= w_tr;
    end
  end
  assign bus.ir_env_o = r_state[0];
  assign bus.seg_len_o = r_len;
  assign bus.seg_lvl_o = r_lvl;
  assign bus.seg_vld_o = r_vld;
endmodule

// File: tb/tb_ir_carrier_strip.sv
// tb_ir_carrier_strip: directed bench with a segment scoreboard for ir_carrier_strip
module tb_ir_carrier_strip;
`ifdef IR_GLITCH_FILT_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 2000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  ir_carrier_strip_if #(.LEN_W(16)) bus();
  ir_carrier_strip dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #20 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.seg_vld_o) begin
      chk("strobe_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("seg_len", bus.seg_len_o, e[15:0]);
        chk("seg_lvl", bus.seg_lvl_o, e[16]);
      end
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  initial begin
    bus.ir_sd_i = 1'b1;
    bus.ir_car_en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", bus.ir_env_o, 1);
    chk("rst_len", bus.seg_len_o, 0);
    chk("rst_lvl", bus.seg_lvl_o, 1);
    chk("rst_vld", bus.seg_vld_o, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tick();
      chk("idle_env", bus.ir_env_o, 1);
    end
    exp_q.push_back({1'b1, 16'hFFFF});
    bus.ir_sd_i = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("bb_entry_env", bus.ir_env_o, (i == LAT) ? 0 : 1);
    end
    chk("sat_seen", exp_q.size(), 0);
    ticks(22500 - LAT);
    exp_q.push_back({1'b0, 16'd22500});
    bus.ir_sd_i = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("bb_exit_env", bus.ir_env_o, (i == LAT) ? 1 : 0);
    end
    chk("bb_seen", exp_q.size(), 0);
    bus.ir_car_en_i = 1'b0;
    ticks(100);
    chk("len_hold", bus.seg_len_o, 22500);
    chk("lvl_hold", bus.seg_lvl_o, 0);
    exp_q.push_back({1'b1, 16'(100 + LAT)});
    for (int i = 0; i < 2000; i++) begin
      bus.ir_sd_i = ((i / 329) % 2) != 0;
      tick();
      chk("car_env", bus.ir_env_o, (i + 1 >= LAT) ? 0 : 1);
      if (i == 1000) bus.ir_car_en_i = 1'b1;
    end
    exp_q.push_back({1'b0, 16'(2000 + HOLD)});
    bus.ir_sd_i = 1'b1;
    for (int i = 1; i <= HOLD + LAT; i++) begin
      tick();
      if (i >= HOLD + LAT - 1) chk("car_tail_env", bus.ir_env_o, (i == HOLD + LAT) ? 1 : 0);
    end
    chk("car_seen", exp_q.size(), 0);
    ticks(50);
    exp_q.push_back({1'b1, 16'(50 + LAT)});
    bus.ir_sd_i = 1'b0;
    ticks(LAT);
    chk("mode_entry_env", bus.ir_env_o, 0);
    ticks(100 - LAT);
    exp_q.push_back({1'b0, 16'd100});
    bus.ir_sd_i = 1'b1;
    ticks(LAT - 1);
    chk("mode_pre_exit_env", bus.ir_env_o, 0);
    tick();
    chk("mode_exit_env", bus.ir_env_o, 1);
    chk("mode_seen", exp_q.size(), 0);
`ifdef IR_GLITCH_FILT_EN
    ticks(30);
    bus.ir_sd_i = 1'b0;
    ticks(5);
    bus.ir_sd_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("glitch5_env", bus.ir_env_o, 1);
    end
    exp_q.push_back({1'b1, 16'(65 + LAT)});
    bus.ir_sd_i = 1'b0;
    ticks(9);
    bus.ir_sd_i = 1'b1;
    tick();
    chk("glitch9_pre_env", bus.ir_env_o, 1);
    tick();
    chk("glitch9_entry_env", bus.ir_env_o, 0);
    exp_q.push_back({1'b0, 16'd9});
    ticks(9);
    chk("glitch9_exit_env", bus.ir_env_o, 1);
    chk("glitch9_seen", exp_q.size(), 0);
`endif
    ticks(20);
    exp_q.push_back({1'b1, 16'(20 + LAT)});
    bus.ir_sd_i = 1'b0;
    ticks(LAT);
    chk("rstmid_entry_env", bus.ir_env_o, 0);
    chk("rstmid_space_seen", exp_q.size(), 0);
    ticks(10);
    #5;
    rst_n = 1'b0;
    #1;
    chk("rstmid_env", bus.ir_env_o, 1);
    chk("rstmid_vld", bus.seg_vld_o, 0);
    chk("rstmid_len", bus.seg_len_o, 0);
    chk("rstmid_lvl", bus.seg_lvl_o, 1);
    bus.ir_sd_i = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_env", bus.ir_env_o, 1);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
